// File: rtl/seq_throughout_monitor_if.sv
// Bundle of the control and report signals of seq_throughout_monitor.
//   slave  modport : the monitor (takes controls, drives verdicts/counters)
//   master modport : whatever drives the controls and reads the report
// Controls : en, start, qual, cond_a, cond_b, clr_cnt
// Report   : busy, match_pulse, fail_pulse, fail_code, match_lat,
//            pass_cnt, fail_cnt, drop_cnt
// start is a single-cycle strobe sampled at the clock edge. It has no ready
// handshake. A start that arrives while busy is counted in drop_cnt and
// otherwise ignored.
interface seq_throughout_monitor_if #(
  parameter int CNT_W = 8,
  parameter int LAT_W = 3
);
  logic             en;
  logic             start;
  logic             qual;
  logic             cond_a;
  logic             cond_b;
  logic             clr_cnt;
  logic             busy;
  logic             match_pulse;
  logic             fail_pulse;
  logic [1:0]       fail_code;
  logic [LAT_W-1:0] match_lat;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport slave (
    input  en, start, qual, cond_a, cond_b, clr_cnt,
    output busy, match_pulse, fail_pulse, fail_code, match_lat,
           pass_cnt, fail_cnt, drop_cnt
  );

  modport master (
    output en, start, qual, cond_a, cond_b, clr_cnt,
    input  busy, match_pulse, fail_pulse, fail_code, match_lat,
           pass_cnt, fail_cnt, drop_cnt
  );
endinterface

// File: rtl/seq_throughout_monitor.sv
// Hardware evaluator for
//   first_match(qual throughout (##[MIN_DLY:MAX_DLY] (cond_a && cond_b)))
// The monitor runs one attempt at a time, and a start strobe launches each
// attempt. Every attempt ends in exactly one registered match pulse or one
// fail pulse. The only exceptions are an en drop and a reset, which end the
// attempt silently. Saturating counters tally the outcomes.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   mon   : seq_throughout_monitor_if.slave (controls in, report out)
// The FSM state is visible on mon.busy (1 == ARMED).
module seq_throughout_monitor #(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 4,
  parameter int CNT_W   = 8,
  parameter int LAT_W   = $clog2(MAX_DLY + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_throughout_monitor_if.slave mon
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ARMED = 1'b1;

  localparam logic [1:0] CODE_QUAL    = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  localparam logic [LAT_W-1:0] MIN_OFF = LAT_W'(MIN_DLY);
  localparam logic [LAT_W-1:0] MAX_OFF = LAT_W'(MAX_DLY);

  logic [0:0]       state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;       // cycles since the start edge
  logic             match_q, match_d;
  logic             fail_q, fail_d;
  logic [1:0]       code_q, code_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] failc_q, failc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             pass_inc, fail_inc, drop_inc;
  logic             target;

  assign target = mon.cond_a & mon.cond_b;

  function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic clr);
    if (clr)
      return '0;
    else if (inc && (cur != {CNT_W{1'b1}}))
      return cur + CNT_W'(1);
    else
      return cur;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    match_d  = 1'b0;
    fail_d   = 1'b0;
    code_d   = code_q;
    lat_d    = lat_q;
    pass_inc = 1'b0;
    fail_inc = 1'b0;
    drop_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The start edge itself is offset 0.
        if (mon.en && mon.start) begin
          if (!mon.qual) begin
            fail_d   = 1'b1;
            code_d   = CODE_QUAL;
            fail_inc = 1'b1;
          end else if (target && (MIN_DLY == 0)) begin
            match_d  = 1'b1;
            lat_d    = '0;
            pass_inc = 1'b1;
          end else begin
            state_d = S_ARMED;
            cnt_d   = LAT_W'(1);
          end
        end
      end

      S_ARMED: begin
        // A start while an attempt is running never restarts the attempt.
        // This holds in the deciding cycle too.
        if (mon.en && mon.start)
          drop_inc = 1'b1;

        if (!mon.en) begin
          state_d = S_IDLE;
        end else if (!mon.qual) begin
          // A qual drop beats a simultaneous target.
          state_d  = S_IDLE;
          fail_d   = 1'b1;
          code_d   = CODE_QUAL;
          fail_inc = 1'b1;
        end else if (target && (cnt_q >= MIN_OFF)) begin
          // This branch comes before the timeout check, so a match at
          // cnt == MAX_DLY wins.
          state_d  = S_IDLE;
          match_d  = 1'b1;
          lat_d    = cnt_q;
          pass_inc = 1'b1;
        end else if (cnt_q == MAX_OFF) begin
          state_d  = S_IDLE;
          fail_d   = 1'b1;
          code_d   = CODE_TIMEOUT;
          fail_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    pass_d  = sat_next(pass_q, pass_inc, mon.clr_cnt);
    failc_d = sat_next(failc_q, fail_inc, mon.clr_cnt);
    drop_d  = sat_next(drop_q, drop_inc, mon.clr_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 2'b00;
      lat_q   <= '0;
      pass_q  <= '0;
      failc_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      lat_q   <= lat_d;
      pass_q  <= pass_d;
      failc_q <= failc_d;
      drop_q  <= drop_d;
    end
  end

  assign mon.busy        = (state_q == S_ARMED);
  assign mon.match_pulse = match_q;
  assign mon.fail_pulse  = fail_q;
  assign mon.fail_code   = code_q;
  assign mon.match_lat   = lat_q;
  assign mon.pass_cnt    = pass_q;
  assign mon.fail_cnt    = failc_q;
  assign mon.drop_cnt    = drop_q;

endmodule

// File: tb/tb_seq_throughout_monitor.sv
module tb_seq_throughout_monitor;

  localparam int LAT_W = 3;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  seq_throughout_monitor_if #(.CNT_W(8), .LAT_W(LAT_W)) bus ();
  seq_throughout_monitor_if #(.CNT_W(2), .LAT_W(LAT_W)) bus2 ();

  seq_throughout_monitor #(.MIN_DLY(1), .MAX_DLY(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  seq_throughout_monitor #(.MIN_DLY(1), .MAX_DLY(4), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic start, input logic qual,
                       input logic tgt);
    bus.en     = en;
    bus.start  = start;
    bus.qual   = qual;
    bus.cond_a = tgt;
    bus.cond_b = tgt;
  endtask

  task automatic drive2(input logic start, input logic tgt, input logic clr);
    bus2.en      = 1'b1;
    bus2.qual    = 1'b1;
    bus2.start   = start;
    bus2.cond_a  = tgt;
    bus2.cond_b  = tgt;
    bus2.clr_cnt = clr;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    bus.clr_cnt = 1'b0;
    drive2(1'b0, 1'b0, 1'b0);
    bus2.en = 1'b0;
    #2;
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_match", 32'(bus.match_pulse), 32'd0);
    check("rst_fail",  32'(bus.fail_pulse), 32'd0);
    check("rst_code",  32'(bus.fail_code), 32'd0);
    check("rst_pass",  32'(bus.pass_cnt), 32'd0);
    check("rst_drop",  32'(bus.drop_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. target at E2 -> match, lat 2
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();            // E0
    check("t1_busy_e0", 32'(bus.busy), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();            // E1
    check("t1_nopulse_e1", 32'(bus.match_pulse), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1); tick();            // E2
    check("t1_match", 32'(bus.match_pulse), 32'd1);
    check("t1_fail",  32'(bus.fail_pulse), 32'd0);
    check("t1_lat",   32'(bus.match_lat), 32'd2);
    check("t1_pass",  32'(bus.pass_cnt), 32'd1);
    check("t1_busy",  32'(bus.busy), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
    check("t1_pulse_1cyc", 32'(bus.match_pulse), 32'd0);

    // 2. qual drop together with target at E2 -> fail 01
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();            // E0
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();            // E1
    drive(1'b1, 1'b0, 1'b0, 1'b1); tick();            // E2
    check("t2_fail",  32'(bus.fail_pulse), 32'd1);
    check("t2_match", 32'(bus.match_pulse), 32'd0);
    check("t2_code",  32'(bus.fail_code), 32'd1);
    check("t2_failc", 32'(bus.fail_cnt), 32'd1);
    check("t2_pass",  32'(bus.pass_cnt), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();

    // 3a. no target through E4 -> timeout 10
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();            // E0
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick(); tick(); tick(); // E1..E3
    check("t3a_busy_e3", 32'(bus.busy), 32'd1);
    check("t3a_nofail_e3", 32'(bus.fail_pulse), 32'd0);
    tick();                                            // E4
    check("t3a_fail",  32'(bus.fail_pulse), 32'd1);
    check("t3a_code",  32'(bus.fail_code), 32'd2);
    check("t3a_failc", 32'(bus.fail_cnt), 32'd2);
    check("t3a_busy",  32'(bus.busy), 32'd0);
    tick();

    // 3b. target exactly at E4 -> match, lat 4
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();            // E0
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick(); tick(); tick(); // E1..E3
    drive(1'b1, 1'b0, 1'b1, 1'b1); tick();            // E4
    check("t3b_match", 32'(bus.match_pulse), 32'd1);
    check("t3b_fail",  32'(bus.fail_pulse), 32'd0);
    check("t3b_lat",   32'(bus.match_lat), 32'd4);
    check("t3b_pass",  32'(bus.pass_cnt), 32'd2);
    check("t3b_failc", 32'(bus.fail_cnt), 32'd2);
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();

    // 4. target at E0 (below MIN_DLY), E1 and E2 -> single match, lat 1
    drive(1'b1, 1'b1, 1'b1, 1'b1); tick();            // E0
    check("t4_e0_nomatch", 32'(bus.match_pulse), 32'd0);
    check("t4_e0_busy",    32'(bus.busy), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1); tick();            // E1
    check("t4_match", 32'(bus.match_pulse), 32'd1);
    check("t4_lat",   32'(bus.match_lat), 32'd1);
    tick();                                            // E2, target still high
    check("t4_single", 32'(bus.match_pulse), 32'd0);
    check("t4_pass",   32'(bus.pass_cnt), 32'd3);
    check("t4_lat_hold", 32'(bus.match_lat), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();

    // 5. starts at E1/E2 dropped; decide at E3; new start at E4 accepted
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();            // E0
    tick();                                            // E1
    tick();                                            // E2
    check("t5_drop_e2", 32'(bus.drop_cnt), 32'd2);
    check("t5_busy_e2", 32'(bus.busy), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1); tick();            // E3
    check("t5_match", 32'(bus.match_pulse), 32'd1);
    check("t5_lat",   32'(bus.match_lat), 32'd3);
    check("t5_drop",  32'(bus.drop_cnt), 32'd2);
    check("t5_pass",  32'(bus.pass_cnt), 32'd4);
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();            // E4
    check("t5_rearm", 32'(bus.busy), 32'd1);
    check("t5_drop_e4", 32'(bus.drop_cnt), 32'd2);
    drive(1'b1, 1'b0, 1'b1, 1'b1); tick();            // E5
    check("t5_match2", 32'(bus.match_pulse), 32'd1);
    check("t5_lat2",   32'(bus.match_lat), 32'd1);
    check("t5_pass2",  32'(bus.pass_cnt), 32'd5);
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();

    // en low while armed -> silent abort
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
    check("en_armed", 32'(bus.busy), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b1); tick();
    check("en_abort_busy", 32'(bus.busy), 32'd0);
    check("en_abort_match", 32'(bus.match_pulse), 32'd0);
    check("en_abort_fail", 32'(bus.fail_pulse), 32'd0);
    check("en_abort_pass", 32'(bus.pass_cnt), 32'd5);
    check("en_abort_failc", 32'(bus.fail_cnt), 32'd2);

    // 6. reset mid-attempt -> everything 0 immediately
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
    check("t6_armed", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy",  32'(bus.busy), 32'd0);
    check("t6_code",  32'(bus.fail_code), 32'd0);
    check("t6_lat",   32'(bus.match_lat), 32'd0);
    check("t6_pass",  32'(bus.pass_cnt), 32'd0);
    check("t6_failc", 32'(bus.fail_cnt), 32'd0);
    check("t6_drop",  32'(bus.drop_cnt), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("t6_no_pulse", 32'(bus.match_pulse | bus.fail_pulse), 32'd0);

    // CNT_W=2 instance: 5 back-to-back passes saturate at 3
    for (int i = 0; i < 5; i++) begin
      drive2(1'b1, 1'b0, 1'b0); tick();
      drive2(1'b0, 1'b1, 1'b0); tick();
      check("sat_pulse", 32'(bus2.match_pulse), 32'd1);
    end
    check("sat_pass", 32'(bus2.pass_cnt), 32'd3);
    check("sat_failc", 32'(bus2.fail_cnt), 32'd0);
    // clr_cnt together with a pass -> 0
    drive2(1'b1, 1'b0, 1'b0); tick();
    drive2(1'b0, 1'b1, 1'b1); tick();
    check("clr_match", 32'(bus2.match_pulse), 32'd1);
    check("clr_pass",  32'(bus2.pass_cnt), 32'd0);
    drive2(1'b0, 1'b0, 1'b0); tick();
    check("clr_hold", 32'(bus2.pass_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
